// File: rtl/instr_control.sv
// Instruction FSM: captures an instruction word, then sequences register-file and ALU strobes.
// Optional trap: define ILLEGAL_TRAP_EN so that illegal instructions halt with err=1 until reset.
module instr_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  vsel,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        err
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic        w_q, w_d;
    logic [2:0]  readnum_q, readnum_d;
    logic [2:0]  writenum_q, writenum_d;
    logic        write_q, write_d;
    logic        loada_q, loada_d;
    logic        loadb_q, loadb_d;
    logic        loadc_q, loadc_d;
    logic        loads_q, loads_d;
    logic [1:0]  vsel_q, vsel_d;
    logic        asel_q, asel_d;
    logic        bsel_q, bsel_d;
    logic [1:0]  shift_q, shift_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic        err_q, err_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

    assign opcode     = ir_q[15:13];
    assign op         = ir_q[12:11];
    assign rn         = ir_q[10:8];
    assign rd         = ir_q[7:5];
    assign sh         = ir_q[4:3];
    assign rm         = ir_q[2:0];
    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);

    // Next state and IR capture
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    ir_d    = in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm)
                    state_d = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn)
                    state_d = S_GET_B;
                else if (is_alu)
                    state_d = S_GET_A;
                else
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_WAIT;
`endif
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            S_HALT:
`ifdef ILLEGAL_TRAP_EN
                state_d = S_HALT;
`else
                state_d = S_WAIT;
`endif
            default:     state_d = S_WAIT;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered copies line up
    // with the state they describe. Only DECODE entry rewrites IR, and DECODE uses no fields.
    always_comb begin
        w_d        = 1'b0;
        readnum_d  = 3'd0;
        writenum_d = 3'd0;
        write_d    = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        vsel_d     = 2'b00;
        asel_d     = 1'b0;
        bsel_d     = 1'b0;
        shift_d    = 2'b00;
        alu_op_d   = 2'b00;
        err_d      = 1'b0;
        case (state_d)
            S_WAIT: w_d = 1'b1;
            S_WRITE_IMM: begin
                writenum_d = rn;
                vsel_d     = 2'b10;
                write_d    = 1'b1;
            end
            S_GET_A: begin
                readnum_d = rn;
                loada_d   = 1'b1;
            end
            S_GET_B: begin
                readnum_d = rm;
                loadb_d   = 1'b1;
            end
            S_ALU: begin
                shift_d  = sh;
                asel_d   = is_mov_reg || is_mvn;
                alu_op_d = is_mov_reg ? 2'b00 : op;
                loads_d  = is_cmp;
                loadc_d  = !is_cmp;
            end
            S_WRITE_REG: begin
                writenum_d = rd;
                vsel_d     = 2'b00;
                write_d    = 1'b1;
            end
            S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                err_d = 1'b1;
`else
                err_d = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_WAIT;
            ir_q       <= 16'd0;
            w_q        <= 1'b1;
            readnum_q  <= 3'd0;
            writenum_q <= 3'd0;
            write_q    <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            vsel_q     <= 2'b00;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            shift_q    <= 2'b00;
            alu_op_q   <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            w_q        <= w_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            write_q    <= write_d;
            loada_q    <= loada_d;
            loadb_q    <= loadb_d;
            loadc_q    <= loadc_d;
            loads_q    <= loads_d;
            vsel_q     <= vsel_d;
            asel_q     <= asel_d;
            bsel_q     <= bsel_d;
            shift_q    <= shift_d;
            alu_op_q   <= alu_op_d;
            err_q      <= err_d;
        end
    end

    assign w        = w_q;
    assign readnum  = readnum_q;
    assign writenum = writenum_q;
    assign write    = write_q;
    assign loada    = loada_q;
    assign loadb    = loadb_q;
    assign loadc    = loadc_q;
    assign loads    = loads_q;
    assign vsel     = vsel_q;
    assign asel     = asel_q;
    assign bsel     = bsel_q;
    assign shift    = shift_q;
    assign ALUop    = alu_op_q;
    assign err      = err_q;
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_instr_control.sv
// Bench for instr_control: directed instructions, mid-instruction reset, then random instructions
// checked cycle by cycle against a per-instruction micro-step table.
module tb_instr_control;

    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] instr_in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, err;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] ST_NONE  = 5'b00000;
    localparam logic [4:0] ST_WRITE = 5'b10000;
    localparam logic [4:0] ST_LOADA = 5'b01000;
    localparam logic [4:0] ST_LOADB = 5'b00100;
    localparam logic [4:0] ST_LOADC = 5'b00010;
    localparam logic [4:0] ST_LOADS = 5'b00001;

    logic [20:0] seq [$];

    instr_control dut (
        .clk(clk), .reset(reset), .s(s), .in(instr_in), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .vsel(vsel), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5), .err(err)
    );

    always #5 clk = ~clk;

    // {w, readnum, writenum, write/loada/loadb/loadc/loads, vsel, asel, bsel, shift, ALUop, err}
    function automatic logic [20:0] pk(input logic wv, input logic [2:0] rn, input logic [2:0] wn,
                                       input logic [4:0] st, input logic [1:0] vs, input logic as,
                                       input logic [1:0] sh, input logic [1:0] op, input logic e);
        return {wv, rn, wn, st, vs, as, 1'b0, sh, op, e};
    endfunction

    function automatic logic [20:0] observed();
        return {w, readnum, writenum, write, loada, loadb, loadc, loads, vsel, asel, bsel, shift, ALUop, err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs after acceptance, ending in the WAIT cycle (or halt cycles).
    task automatic build_seq(input logic [15:0] ir, output bit halts);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        bit movi, movr, alu;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
        movi = (opc == 3'b110) && (op == 2'b10);
        movr = (opc == 3'b110) && (op == 2'b00);
        alu  = (opc == 3'b101);
        halts = 1'b0;
        seq.delete();
        seq.push_back(pk(0, 0, 0, ST_NONE, 2'b00, 0, 2'b00, 2'b00, 0));
        if (movi) begin
            seq.push_back(pk(0, 0, rn, ST_WRITE, 2'b10, 0, 2'b00, 2'b00, 0));
        end else if (movr || alu) begin
            if (alu && op != 2'b11)
                seq.push_back(pk(0, rn, 0, ST_LOADA, 2'b00, 0, 2'b00, 2'b00, 0));
            seq.push_back(pk(0, rm, 0, ST_LOADB, 2'b00, 0, 2'b00, 2'b00, 0));
            seq.push_back(pk(0, 0, 0, (alu && op == 2'b01) ? ST_LOADS : ST_LOADC, 2'b00,
                             movr || (op == 2'b11), sh, movr ? 2'b00 : op, 0));
            if (!(alu && op == 2'b01))
                seq.push_back(pk(0, 0, rd, ST_WRITE, 2'b00, 0, 2'b00, 2'b00, 0));
        end else begin
`ifdef ILLEGAL_TRAP_EN
            halts = 1'b1;
            repeat (10) seq.push_back(pk(0, 0, 0, ST_NONE, 2'b00, 0, 2'b00, 2'b00, 1));
            return;
`endif
        end
        seq.push_back(pk(1, 0, 0, ST_NONE, 2'b00, 0, 2'b00, 2'b00, 0));
    endtask

    task automatic apply_reset(input logic s_val, input logic [15:0] in_val);
        reset = 1'b1; s = s_val; instr_in = in_val;
        step();
        reset = 1'b0; s = 1'b0;
        chk("reset_outputs", observed(), pk(1, 0, 0, ST_NONE, 2'b00, 0, 2'b00, 2'b00, 0));
        chk("reset_sximm8", sximm8, 16'h0000);
        chk("reset_sximm5", sximm5, 16'h0000);
    endtask

    // Called at a WAIT cycle; drives random s/in while the instruction runs.
    task automatic run_instr(input logic [15:0] ir);
        bit halts;
        logic [15:0] sx8, sx5;
        sx8 = {{8{ir[7]}}, ir[7:0]};
        sx5 = {{11{ir[4]}}, ir[4:0]};
        build_seq(ir, halts);
        s = 1'b1; instr_in = ir;
        for (int i = 0; i < seq.size(); i++) begin
            step();
            chk($sformatf("ir=%h cyc%0d", ir, i + 1), observed(), seq[i]);
            chk($sformatf("ir=%h sximm8", ir), sximm8, sx8);
            chk($sformatf("ir=%h sximm5", ir), sximm5, sx5);
            s = 1'($urandom);
            instr_in = 16'($urandom);
        end
        s = 1'b0;
        if (halts) apply_reset(1'b0, 16'h0000);
        $display("instr %h done cycles=%0d", ir, seq.size());
    endtask

    initial begin
        logic [15:0] ir;
        reset = 1'b1; s = 1'b0; instr_in = 16'h0000;
        step();
        apply_reset(1'b0, 16'h0000);
        step();
        chk("idle_wait", observed(), pk(1, 0, 0, ST_NONE, 2'b00, 0, 2'b00, 2'b00, 0));

        run_instr(16'hD105);
        run_instr(16'hA2A0);
        run_instr(16'hAB01);
        run_instr(16'hC0F9);
        run_instr(16'hE000);

        // Reset during GET_B of an ADD, with s held high to show reset dominates
        s = 1'b1; instr_in = 16'hA2A0;
        step();
        chk("abort_decode", observed(), pk(0, 0, 0, ST_NONE, 2'b00, 0, 2'b00, 2'b00, 0));
        s = 1'b0;
        step();
        step();
        chk("abort_get_b", observed(), pk(0, 0, 0, ST_LOADB, 2'b00, 0, 2'b00, 2'b00, 0));
        apply_reset(1'b1, 16'hD105);
        step();
        chk("abort_after", observed(), pk(1, 0, 0, ST_NONE, 2'b00, 0, 2'b00, 2'b00, 0));
        $display("reset abort done");

        for (int n = 0; n < 40; n++) begin
            ir = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ir[15:11] = 5'b11010;
                1: ir[15:11] = 5'b11000;
                2: ir[15:11] = 5'b10100;
                3: ir[15:11] = 5'b10101;
                4: ir[15:11] = 5'b10110;
                5: ir[15:11] = 5'b10111;
                default: ;
            endcase
            run_instr(ir);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
